// File: rtl/spi_read_sequencer_if.sv
// Requester-side and SPI-side signal bundle for spi_read_sequencer.
// The master modport is the sequencer; the slave modport is its environment
// (requesters plus the SPI slave device).
interface spi_read_sequencer_if #(
   parameter int NREQ = 4,
   parameter int ID_W = 2
);
   logic              cpol;
   logic              cpha;
   logic [NREQ-1:0]   req;
   logic [8*NREQ-1:0] addr;
   logic [NREQ-1:0]   gnt;
   logic [ID_W-1:0]   gnt_id;
   logic              busy;
   logic              done;
   logic [7:0]        rdata;
   logic              ss;
   logic              sck;
   logic              mosi;
   logic              miso;

   modport master (
      input  cpol, cpha, req, addr, miso,
      output gnt, gnt_id, busy, done, rdata, ss, sck, mosi
   );

   modport slave (
      output cpol, cpha, req, addr, miso,
      input  gnt, gnt_id, busy, done, rdata, ss, sck, mosi
   );
endinterface

// File: rtl/spi_read_sequencer.sv
// Round-robin multi-requester SPI register-read master.
// Every visible output is a flop loaded from the output logic of the current
// state, so outputs trail the state register by one clock; ss therefore rises
// two clocks after ARB is entered and done pulses 2 + 34*CLK_DIV clocks after it.
module spi_read_sequencer #(
   parameter int NREQ    = 4,
   parameter int ID_W    = 2,
   parameter int CLK_DIV = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   spi_read_sequencer_if.master  bus
);
   localparam int              DIV_W    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [ID_W-1:0]  PTR_INIT = ID_W'(NREQ - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ARB   = 3'd1,
      S_SETUP = 3'd2,
      S_SHIFT = 3'd3,
      S_HOLD  = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t           state_q, state_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [4:0]       edge_q, edge_d;
   logic [ID_W-1:0]  ptr_q, ptr_d;
   logic [7:0]       addr_q, addr_d;
   logic             cpol_q, cpol_d;
   logic             cpha_q, cpha_d;
   logic [7:0]       shadow_q, shadow_d;
   logic [NREQ-1:0]  gnt_q, gnt_d;
   logic [ID_W-1:0]  gnt_id_q, gnt_id_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [7:0]       rdata_q, rdata_d;
   logic             ss_q, ss_d;
   logic             sck_q, sck_d;
   logic             mosi_q, mosi_d;

   logic [ID_W:0]    pick;
   logic             pick_found;
   logic [ID_W-1:0]  pick_id;
   logic             div_last;
   logic [5:0]       bit_sum;
   logic [4:0]       bit_idx;

   // First requester with req high searching upward from ptr+1 with wrap; returns {found, id}.
   function automatic logic [ID_W:0] rr_pick(input logic [NREQ-1:0] r, input logic [ID_W-1:0] p);
      logic [ID_W:0] res;
      logic [ID_W:0] sum;
      logic [ID_W:0] cand;
      res = '0;
      // Walk from the farthest candidate down so the nearest one is written last.
      for (int i = NREQ; i >= 1; i--) begin
         sum  = {1'b0, p} + (ID_W+1)'(i);
         cand = (sum >= (ID_W+1)'(NREQ)) ? (sum - (ID_W+1)'(NREQ)) : sum;
         res  = r[cand[ID_W-1:0]] ? {1'b1, cand[ID_W-1:0]} : res;
      end
      return res;
   endfunction

   assign pick       = rr_pick(bus.req, ptr_q);
   assign pick_found = pick[ID_W];
   assign pick_id    = pick[ID_W-1:0];
   assign div_last   = (div_q == DIV_LAST);

   // cpha=0 shifts a new bit on trailing edges (bit index rounds up), cpha=1 on leading edges.
   assign bit_sum = {1'b0, edge_q} + (cpha_q ? 6'd0 : 6'd1);
   assign bit_idx = bit_sum[5:1];

   // State register with asynchronous abort on reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state sequencing through arbitration, framing and shifting.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  state_d = (|bus.req) ? S_ARB : S_IDLE;
         S_ARB:   state_d = pick_found ? S_SETUP : S_IDLE;
         S_SETUP: state_d = div_last ? S_SHIFT : S_SETUP;
         S_SHIFT: state_d = (div_last && (edge_q == 5'd31)) ? S_HOLD : S_SHIFT;
         S_HOLD:  state_d = div_last ? S_DONE : S_HOLD;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Output and datapath values for the next clock, decoded from the current state.
   always_comb begin
      div_d    = '0;
      edge_d   = edge_q;
      ptr_d    = ptr_q;
      addr_d   = addr_q;
      cpol_d   = cpol_q;
      cpha_d   = cpha_q;
      shadow_d = shadow_q;
      gnt_d    = gnt_q;
      gnt_id_d = gnt_id_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      rdata_d  = rdata_q;
      ss_d     = 1'b0;
      sck_d    = cpol_q;
      mosi_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            gnt_d    = '0;
            gnt_id_d = '0;
            busy_d   = 1'b0;
            edge_d   = 5'd0;
         end
         S_ARB: begin
            if (pick_found) begin
               ptr_d          = pick_id;
               gnt_d          = '0;
               gnt_d[pick_id] = 1'b1;
               gnt_id_d       = pick_id;
               addr_d         = bus.addr[{pick_id, 3'b000} +: 8];
               cpol_d         = bus.cpol;
               cpha_d         = bus.cpha;
               busy_d         = 1'b1;
            end else begin
               gnt_d    = '0;
               gnt_id_d = '0;
               busy_d   = 1'b0;
            end
         end
         S_SETUP: begin
            ss_d   = 1'b1;
            mosi_d = cpha_q ? 1'b0 : addr_q[0];
            div_d  = div_last ? '0 : div_q + DIV_W'(1);
            edge_d = 5'd0;
         end
         S_SHIFT: begin
            ss_d   = 1'b1;
            sck_d  = cpol_q ^ ~edge_q[0];
            mosi_d = (bit_idx < 5'd8) ? addr_q[bit_idx[2:0]] : 1'b0;
            div_d  = div_last ? '0 : div_q + DIV_W'(1);
            edge_d = div_last ? edge_q + 5'd1 : edge_q;
            // Sample at the clock where sck makes its sampling edge, data half only.
            if ((div_q == '0) && edge_q[4] && (edge_q[0] == cpha_q)) begin
               shadow_d = {bus.miso, shadow_q[7:1]};
            end else begin
               shadow_d = shadow_q;
            end
         end
         S_HOLD: begin
            ss_d  = 1'b1;
            div_d = div_last ? '0 : div_q + DIV_W'(1);
         end
         S_DONE: begin
            done_d  = 1'b1;
            rdata_d = shadow_q;
         end
         default: begin
            gnt_d    = '0;
            gnt_id_d = '0;
            busy_d   = 1'b0;
         end
      endcase
   end

   // Datapath and output registers; reset drops ss and the grant at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_q    <= '0;
         edge_q   <= 5'd0;
         ptr_q    <= PTR_INIT;
         addr_q   <= 8'd0;
         cpol_q   <= 1'b0;
         cpha_q   <= 1'b0;
         shadow_q <= 8'd0;
         gnt_q    <= '0;
         gnt_id_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         rdata_q  <= 8'd0;
         ss_q     <= 1'b0;
         sck_q    <= 1'b0;
         mosi_q   <= 1'b0;
      end else begin
         div_q    <= div_d;
         edge_q   <= edge_d;
         ptr_q    <= ptr_d;
         addr_q   <= addr_d;
         cpol_q   <= cpol_d;
         cpha_q   <= cpha_d;
         shadow_q <= shadow_d;
         gnt_q    <= gnt_d;
         gnt_id_q <= gnt_id_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         rdata_q  <= rdata_d;
         ss_q     <= ss_d;
         sck_q    <= sck_d;
         mosi_q   <= mosi_d;
      end
   end

   assign bus.gnt    = gnt_q;
   assign bus.gnt_id = gnt_id_q;
   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.rdata  = rdata_q;
   assign bus.ss     = ss_q;
   assign bus.sck    = sck_q;
   assign bus.mosi   = mosi_q;
endmodule

// File: doc/spi_read_sequencer.md
Name: spi_read_sequencer

Overview:
- Multi-requester SPI master controller for the register-read SPI slave.
- Round-robin arbitration among NREQ internal requesters for one shared SPI bus.
- Each granted request runs one read transaction:
  - the SPI clock comes from the system clock;
  - an 8-bit register address is shifted out on MOSI;
  - the 8-bit register value is shifted in from MISO;
  - data is returned with a one-cycle done pulse tagged with the requester ID.

Parameters:
- NREQ, 4, number of requesters (2..8)
- ID_W, 2, width of the requester ID (must be at least clog2(NREQ))
- CLK_DIV, 4, system clocks per SCK half-period (minimum 2)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  reset, asynchronous, active-high
- cpol  in  1  SCK idle level; sampled at grant
- cpha  in  1  SPI phase; sampled at grant
- req  in  NREQ  level request per requester; held high until that requester's done
- addr  in  8*NREQ  register address per requester, slice i = addr[8i+7:8i]; sampled at grant
- gnt  out  NREQ  one-hot grant; high from ARB through DONE
- gnt_id  out  ID_W  index of the granted requester, valid while busy
- busy  out  1  transaction in progress
- done  out  1  one-cycle pulse when rdata is valid
- rdata  out  8  read data; holds its value until the next done
- ss  out  1  slave select, active-high
- sck  out  1  SPI clock
- mosi  out  1  master out
- miso  in  1  master in; never high-Z-sensitive; X or Z samples are stored as captured

Behaviour:
- Reset (asynchronous, immediate):
  - ss=0, sck=0, mosi=0, done=0, rdata=0, busy=0, gnt=0, gnt_id=0;
  - round-robin pointer=NREQ-1, so requester 0 wins first;
  - state=IDLE.
- A reset asserted mid-transaction aborts the transaction: no done pulse, ss drops at once.
- States: IDLE -> ARB -> SETUP -> SHIFT -> HOLD -> DONE -> IDLE.
- IDLE:
  - sck = latched cpol (0 after reset), ss=0.
  - Go to ARB when any req bit is high.
- ARB (1 cycle):
  - Winner = first requester with req high, searching from pointer+1 upward with wrap.
  - Latch gnt, gnt_id, that requester's addr, cpol and cpha.
  - Set pointer=winner; busy=1.
- SETUP (CLK_DIV cycles):
  - ss=1, sck=cpol.
  - mosi = addr bit 0 when cpha=0, otherwise 0.
- SHIFT (32*CLK_DIV cycles):
  - SCK toggles every CLK_DIV cycles, giving 32 edges in alternating leading/trailing order, starting from cpol.
  - Bit k (k=0..15) occupies SCK period k.
  - Bits 0..7 carry the address, LSB first. Bits 8..15 carry read data, LSB first: rdata[k-8] is captured from miso.
  - cpha=0: mosi changes on trailing edges (first bit already set in SETUP); miso is sampled on leading edges.
  - cpha=1: mosi changes on leading edges; miso is sampled on trailing edges.
  - mosi=0 for bits 8..15.
  - The captured byte goes to a shadow register; rdata updates only in DONE.
- HOLD (CLK_DIV cycles): sck=cpol, ss=1.
- DONE (1 cycle):
  - ss=0, done=1, rdata=shadow; gnt and gnt_id stay valid this cycle.
  - busy, gnt and gnt_id clear on exit.
- Latency: ss is high for (34*CLK_DIV) cycles. done asserts (2 + 34*CLK_DIV) cycles after the ARB entry edge (138 cycles at CLK_DIV=4).
- Back-to-back: the next request always sees ss=0 for at least the IDLE and ARB cycles, so ss is low for 2 or more cycles between transactions.
- req dropping mid-transaction does not abort: the transaction completes and done still pulses. The requester is not granted again unless req is high at a later ARB.
- All requests high: grants rotate 0,1,2,3,0,...
- Changes to cpol/cpha/addr while busy are ignored.
- Internal counters:
  - half-period divider counts 0..CLK_DIV-1 and wraps;
  - edge counter counts 0..31; SHIFT exits after edge 31's half-period completes.

Test Plan:
- CLK_DIV=4, cpol=0, cpha=0, req=0001, addr0=0x03, slave reg3=0xA5:
  - mosi bits 1,1,0,0,0,0,0,0 on rising edges;
  - done pulse 138 cycles after ARB with rdata=0xA5, gnt_id=0;
  - ss high for exactly 136 cycles.
- Mode sweep, cpol/cpha = 00,01,10,11, addr=0x08, reg8=0x3C:
  - rdata=0x3C in all four modes;
  - sck idle level equals cpol;
  - sampling occurs on the correct edge (checked by the scoreboard).
- req=1111 held continuously with addresses 1..4:
  - four dones with gnt_id 0,1,2,3 in order, then 0 again;
  - ss is low at least 2 cycles between transactions.
- req1 drops to 0 at cycle 40 of its transaction: the transaction still completes, done=1 with gnt_id=1, and requester 1 is not regranted.
- reset asserted at bit 5 of SHIFT: ss=0, sck=0, busy=0 immediately with no done pulse; after release, requester 0 is served first.
- req=0100 then req=0010 asserted during its busy period: grant order is 2 then 1, and rdata holds 2's value until 1's done.
